// File: rtl/decode_inst_queue.sv
`default_nettype none
// decode_inst_queue: circular FIFO of {pc, instr, excp, ecode} words between fetch and decode.
// Rev 1.0 - initial release.

module decode_inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_excp,
  input  logic [5:0]                 in_ecode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_excp,
  output logic [5:0]                 out_ecode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] C_ONE_PTR  = AW'(1);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          excp_mem  [DEPTH];
  logic [5:0]    ecode_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          w_enq;
  logic          w_deq;

  // Handshake status comes only from registered occupancy (plus flush), never from in_valid/out_ready.
  assign in_ready  = (count_q != C_FULL_CNT) && !flush;
  assign out_valid = (count_q != '0);

  assign w_enq = in_valid & in_ready;
  assign w_deq = out_valid & out_ready & !flush;

  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_instr = instr_mem[rd_ptr_q];
  assign out_excp  = excp_mem[rd_ptr_q];
  assign out_ecode = ecode_mem[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_enq) wr_ptr_d = wr_ptr_q + C_ONE_PTR;
      if (w_deq) rd_ptr_d = rd_ptr_q + C_ONE_PTR;
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + C_ONE_CNT;
        2'b01:   count_d = count_q - C_ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is deliberately left unreset; out_* is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
      excp_mem[wr_ptr_q]  <= in_excp;
      ecode_mem[wr_ptr_q] <= in_ecode;
    end
  end

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n) count_q <= C_FULL_CNT)
    else $error("count out of range: %0d", count_q);

endmodule

`default_nettype wire

// File: tb/tb_decode_inst_queue.sv
`default_nettype none
// tb_decode_inst_queue: directed-vector self-checking bench for decode_inst_queue (DEPTH=4).
// Rev 1.0 - initial release.

module tb_decode_inst_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_excp;
  logic [5:0]  in_ecode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_excp;
  logic [5:0]  out_ecode;
  logic [2:0]  count;

  int n_total;
  int n_bad;

  decode_inst_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_excp   (in_excp),
    .in_ecode  (in_ecode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_excp  (out_excp),
    .out_ecode (out_ecode),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Leaves us 1 time unit after the rising edge, registers settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ex, input logic [5:0] ec, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    in_excp   = ex;
    in_ecode  = ec;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);

    // 1: reset then idle, out_ready asserted throughout
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_count",     count,     0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_count",     count,     0);
    check("idle_out_valid", out_valid, 0);

    // 2: fill then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c000000 + 32'(4*i), 32'h00100000 + 32'(i), 1'b0, 6'h0, 1'b0, 1'b0);
      check($sformatf("fill_in_ready%0d", i), in_ready, 1);
      tick();
      check($sformatf("fill_count%0d", i), count, 64'(i+1));
    end
    idle();
    check("full_in_ready",  in_ready,  0);
    check("full_out_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
      check($sformatf("drain_valid%0d", i), out_valid, 1);
      check($sformatf("drain_pc%0d", i),    out_pc,    64'(32'h1c000000 + 32'(4*i)));
      check($sformatf("drain_instr%0d", i), out_instr, 64'(32'h00100000 + 32'(i)));
      tick();
    end
    idle();
    check("drained_count", count,     0);
    check("drained_valid", out_valid, 0);

    // 3: streaming, one-cycle latency then steady count of 1
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h1c000100 + 32'(4*k), 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
      if (k == 0) begin
        check("stream_first_valid", out_valid, 0);
      end else begin
        check($sformatf("stream_valid%0d", k), out_valid, 1);
        check($sformatf("stream_pc%0d", k),    out_pc,    64'(32'h1c000100 + 32'(4*(k-1))));
        check($sformatf("stream_count%0d", k), count,     1);
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
    check("stream_last_pc", out_pc, 64'(32'h1c000114));
    tick();
    idle();
    check("stream_end_count", count, 0);

    // 4: full with simultaneous dequeue: no enqueue that cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c000200 + 32'(4*i), 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h1c000210, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
    check("fulldeq_in_ready", in_ready, 0);
    check("fulldeq_head",     out_pc,   64'(32'h1c000200));
    tick();
    drive(1'b1, 32'h1c000210, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    check("fulldeq_count",    count,    3);
    check("fulldeq_newhead",  out_pc,   64'(32'h1c000204));
    check("fulldeq_ready_rt", in_ready, 1);
    tick();
    idle();
    check("fulldeq_refill", count, 4);

    // 5: flush with count=3, concurrent enq/deq requests ignored
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h1c000300, 32'h0, 1'b0, 6'h0, 1'b1, 1'b1);
    check("flush_pre_count", count,    3);
    check("flush_in_ready",  in_ready, 0);
    tick();
    idle();
    check("flush_count", count,     0);
    check("flush_valid", out_valid, 0);
    drive(1'b1, 32'h1c001000, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    check("postflush_valid_before", out_valid, 0);
    tick();
    idle();
    check("postflush_valid", out_valid, 1);
    check("postflush_pc",    out_pc,    64'(32'h1c001000));
    check("postflush_count", count,     1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
    tick();
    idle();
    check("postflush_empty", count, 0);

    // 6: exception entry travels untouched, then asynchronous reset mid-cycle
    drive(1'b1, 32'h1c002000, 32'hdeadbeef, 1'b1, 6'h08, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h1c002004, 32'h02800000, 1'b0, 6'h00, 1'b0, 1'b0);
    check("excp_valid", out_valid, 1);
    check("excp_flag",  out_excp,  1);
    check("excp_ecode", out_ecode, 64'(6'h08));
    check("excp_instr", out_instr, 64'(32'hdeadbeef));
    tick();
    drive(1'b1, 32'h1c002008, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    tick();
    idle();
    check("prereset_count", count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_valid",    out_valid, 0);
    check("areset_count",    count,     0);
    check("areset_in_ready", in_ready,  1);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_reset_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
